// File: rtl/fp32_pkg.sv
// Shared binary32 constants and the unpack helper used by the FP add/sub front end.
// Each operand is unpacked into a sign, an effective exponent and a 25-bit significand.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = 25;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] m;
  } unpacked_t;

  // Zero and subnormals share exponent 1 so their significands line up with normals.
  function automatic unpacked_t unpack_fp32(input logic [31:0] x);
    unpacked_t r;
    logic      hidden;
    r.s = x[31];
    if (x[30:23] == 8'd0) begin
      r.e    = 8'd1;
      hidden = 1'b0;
    end else begin
      r.e    = x[30:23];
      hidden = 1'b1;
    end
    r.m = {hidden, x[22:0], 1'b0};
    return r;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpack of one binary32 operand into {sign, effective exponent, significand}.
module fp_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]      x_i,
  output logic             s_o,
  output logic [EXP_W-1:0] e_o,
  output logic [SIG_W-1:0] m_o
);

  unpacked_t u_s;

  assign u_s = unpack_fp32(x_i);
  assign s_o = u_s.s;
  assign e_o = u_s.e;
  assign m_o = u_s.m;

endmodule

// File: rtl/fp_add_sub_pre_align.sv
// First stage of the FP adder/subtractor: unpack both operands, put the larger magnitude
// on the A side, and register the sorted fields for the alignment shifter.
module fp_add_sub_pre_align
  import fp32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       A,
  input  logic [31:0]       B,
  output logic              out_valid,
  output logic              Sa,
  output logic              Sb,
  output logic [EXP_W-1:0]  Ea,
  output logic [EXP_W-1:0]  Eb,
  output logic [SIG_W-1:0]  Ma,
  output logic [SIG_W-1:0]  Mb,
  output logic              Swap
);

  logic             sa_in_s, sb_in_s;
  logic [EXP_W-1:0] ea_in_s, eb_in_s;
  logic [SIG_W-1:0] ma_in_s, mb_in_s;

  logic             sa_d, sb_d, swap_d;
  logic [EXP_W-1:0] ea_d, eb_d;
  logic [SIG_W-1:0] ma_d, mb_d;

  logic             valid_q, sa_q, sb_q, swap_q;
  logic [EXP_W-1:0] ea_q, eb_q;
  logic [SIG_W-1:0] ma_q, mb_q;

  fp_unpack u_unpack_a (
    .x_i (A),
    .s_o (sa_in_s),
    .e_o (ea_in_s),
    .m_o (ma_in_s)
  );

  fp_unpack u_unpack_b (
    .x_i (B),
    .s_o (sb_in_s),
    .e_o (eb_in_s),
    .m_o (mb_in_s)
  );

  // Magnitude order is the unsigned compare of {Eeff, M}; ties keep the original order.
  assign swap_d = ({eb_in_s, mb_in_s} > {ea_in_s, ma_in_s});

  // Swap mux: signs travel with their operand.
  always_comb begin
    sa_d = sa_in_s;
    sb_d = sb_in_s;
    ea_d = ea_in_s;
    eb_d = eb_in_s;
    ma_d = ma_in_s;
    mb_d = mb_in_s;
    if (swap_d) begin
      sa_d = sb_in_s;
      sb_d = sa_in_s;
      ea_d = eb_in_s;
      eb_d = ea_in_s;
      ma_d = mb_in_s;
      mb_d = ma_in_s;
    end else begin
      sa_d = sa_in_s;
      sb_d = sb_in_s;
      ea_d = ea_in_s;
      eb_d = eb_in_s;
      ma_d = ma_in_s;
      mb_d = mb_in_s;
    end
  end

  // Output register: captures every cycle, data is qualified downstream by out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      swap_q  <= 1'b0;
      ea_q    <= 8'd0;
      eb_q    <= 8'd0;
      ma_q    <= 25'd0;
      mb_q    <= 25'd0;
    end else begin
      valid_q <= in_valid;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      swap_q  <= swap_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
    end
  end

  assign out_valid = valid_q;
  assign Sa        = sa_q;
  assign Sb        = sb_q;
  assign Ea        = ea_q;
  assign Eb        = eb_q;
  assign Ma        = ma_q;
  assign Mb        = mb_q;
  assign Swap      = swap_q;

endmodule

// File: tb/tb_fp_add_sub_pre_align.sv
// Scoreboard bench for fp_add_sub_pre_align: directed cases, randomized operand pairs
// and asynchronous reset, checked against an arithmetic reference model.
module tb_fp_add_sub_pre_align;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] A, B;
  logic        out_valid, Sa, Sb, Swap;
  logic [7:0]  Ea, Eb;
  logic [24:0] Ma, Mb;

  typedef struct {
    logic [69:0] v;
    int          tag;
  } exp_t;

  exp_t        q[$];
  int          vectors;
  int          miscompares;
  exp_t        mon_e;
  logic [69:0] mon_act;

  fp_add_sub_pre_align dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .Sa        (Sa),
    .Sb        (Sb),
    .Ea        (Ea),
    .Eb        (Eb),
    .Ma        (Ma),
    .Mb        (Mb),
    .Swap      (Swap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Magnitude key = Eeff * 2^25 + M, with M = hidden*2^24 + frac*2
  function automatic longint mag_key(input logic [31:0] x);
    longint e_raw, eeff, m;
    e_raw = longint'(x[30:23]);
    eeff  = (e_raw == 0) ? 1 : e_raw;
    m     = ((e_raw != 0) ? 64'd16777216 : 64'd0) + longint'(x[22:0]) * 2;
    return eeff * 64'd33554432 + m;
  endfunction

  function automatic exp_t model(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input int tag);
    exp_t        r;
    longint      ka, kb, kbig, ksml;
    logic        sw, sbig, ssml;
    logic [7:0]  ebig, esml;
    logic [24:0] mbig, msml;
    ka   = mag_key(a);
    kb   = mag_key(b);
    sw   = (kb > ka);
    kbig = sw ? kb : ka;
    ksml = sw ? ka : kb;
    sbig = sw ? b[31] : a[31];
    ssml = sw ? a[31] : b[31];
    ebig = 8'(kbig / 64'd33554432);
    esml = 8'(ksml / 64'd33554432);
    mbig = 25'(kbig % 64'd33554432);
    msml = 25'(ksml % 64'd33554432);
    r.v   = {v, sw, sbig, ssml, ebig, esml, mbig, msml};
    r.tag = tag;
    return r;
  endfunction

  task automatic drive_now(input logic v, input logic [31:0] a, input logic [31:0] b,
                           input int tag);
    in_valid = v;
    A        = a;
    B        = b;
    q.push_back(model(v, a, b, tag));
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input int tag);
    @(negedge clk);
    drive_now(v, a, b, tag);
  endtask

  task automatic check_zero(input int tag);
    vectors++;
    if ({out_valid, Swap, Sa, Sb, Ea, Eb, Ma, Mb} !== 70'd0) begin
      miscompares++;
      $display("FAIL reset_zero tag=%0d act=%h exp=0", tag,
               {out_valid, Swap, Sa, Sb, Ea, Eb, Ma, Mb});
    end
  endtask

  // Monitor: every cycle out of reset the DUT presents exactly one queued expectation
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      mon_act = {out_valid, Swap, Sa, Sb, Ea, Eb, Ma, Mb};
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL no_expect act=%h", mon_act);
      end else begin
        mon_e = q.pop_front();
        if (mon_act !== mon_e.v) begin
          miscompares++;
          $display("FAIL cycle tag=%0d act=%h exp=%h", mon_e.tag, mon_act, mon_e.v);
        end
      end
    end
  end

  logic [31:0] ra, rb;
  logic [31:0] dir_a [6] = '{32'h3F800000, 32'h40000000, 32'h40220000,
                             32'h41000000, 32'h63E00000, 32'h3F880000};
  logic [31:0] dir_b [6] = '{32'h3F800000, 32'h3FA00000, 32'h44000000,
                             32'h00000000, 32'h00800040, 32'h3FC00000};

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    A           = 32'h3F800000;
    B           = 32'h40000000;
    #2;
    check_zero(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_now(1'b1, dir_a[0], dir_b[0], 1);
    for (int i = 1; i < 6; i++) step(1'b1, dir_a[i], dir_b[i], i + 1);
    // Spot-check one directed result against the literal spec values
    @(posedge clk);
    #2;
    vectors++;
    if ({Swap, Ea, Ma, Eb, Mb} !== {1'b1, 8'h7F, 25'h1800000, 8'h7F, 25'h1100000}) begin
      miscompares++;
      $display("FAIL dir6_literal act=%h", {Swap, Ea, Ma, Eb, Mb});
    end
    step(1'b0, 32'hC0400000, 32'h40800000, 7);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 4))
        0: ;
        1: rb = ra;
        2: rb[30:23] = ra[30:23];
        3: ra[30:23] = 8'd0;
        4: begin
          ra[30:23] = 8'($urandom_range(0, 1));
          rb[30:23] = ($urandom_range(0, 1) == 0) ? 8'd255 : 8'($urandom_range(0, 1));
        end
        default: ;
      endcase
      step(($urandom_range(0, 3) != 0), ra, rb, 100 + i);
    end

    // Asynchronous reset mid-stream, asserted between edges
    step(1'b1, 32'h40220000, 32'h44000000, 500);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check_zero(501);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_zero(502);
    @(negedge clk);
    rst_n = 1'b1;
    drive_now(1'b1, 32'h41000000, 32'h00000000, 503);
    step(1'b1, 32'hBF880000, 32'h3FC00000, 504);
    step(1'b0, 32'h00000000, 32'h00000000, 505);

    @(posedge clk);
    #3;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
